// File: rtl/vga_monitor.sv
// Passive VGA sink: recovers hsync/vsync timing from vgaData, checks it against the
// configured mode, and reports active pixels, per-frame checksums and timing violations.
module vga_monitor #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [13:0] vgaData,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [15:0] frame_count,
    output logic        timing_err,
    output logic [7:0]  err_count
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] H_ACT_LO = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_HI = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0]  V_ACT_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_ACT_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc_h(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc_v(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc_e(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state, state_nxt;
    logic        acq_err_q, acq_err_nxt;

    logic [13:0] d1_p0;
    logic [1:0]  d2_p1;
    logic [10:0] h_q;
    logic [9:0]  v_q;
    logic [15:0] run_sum;

    logic        h_fall, h_rise, v_fall, v_rise;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        viol;
    logic        in_active;
    logic        pix_load;
    logic        frame_end;
    logic [15:0] sum_nxt;

    // Stage p0/p1: edge detection on the sync bits of the two-deep sample pipe
    assign h_fall = d2_p1[1] & ~d1_p0[13];
    assign h_rise = ~d2_p1[1] & d1_p0[13];
    assign v_fall = d2_p1[0] & ~d1_p0[12];
    assign v_rise = ~d2_p1[0] & d1_p0[12];

    // Counters index the d1 sample: the first low hsync sample is column 0
    assign h_cnt = h_fall ? 11'd0 : sat_inc_h(h_q);
    assign v_cnt = v_fall ? 10'd0 : (h_fall ? sat_inc_v(v_q) : v_q);

    always_comb begin
        viol = 1'b0;
        if (state != SEARCH) begin
            viol = (h_fall && (h_q   != H_LAST))   ||
                   (h_rise && (h_cnt != H_SYNC_W)) ||
                   (v_fall && (v_q   != V_LAST))   ||
                   (v_rise && (v_cnt != V_SYNC_W));
        end
    end

    assign in_active = (h_cnt >= H_ACT_LO) && (h_cnt <= H_ACT_HI) &&
                       (v_cnt >= V_ACT_LO) && (v_cnt <= V_ACT_HI);
    assign pix_load  = (state == LOCKED) && !viol && in_active;
    assign frame_end = (state == LOCKED) && v_fall && !viol;
    assign sum_nxt   = run_sum + (pix_valid ? {4'd0, pix_rgb} : 16'd0);
    assign locked    = (state == LOCKED);

    always_comb begin
        state_nxt   = state;
        acq_err_nxt = acq_err_q;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_nxt   = ACQUIRE;
                    acq_err_nxt = 1'b0;
                end
            end
            ACQUIRE: begin
                if (v_fall) begin
                    // A frame with any violation, including one at this edge, restarts acquisition
                    if (!acq_err_q && !viol) state_nxt = LOCKED;
                    acq_err_nxt = 1'b0;
                end else if (viol) begin
                    acq_err_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (viol) state_nxt = SEARCH;
            end
            default: begin
                state_nxt   = SEARCH;
                acq_err_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            acq_err_q <= 1'b0;
            d1_p0     <= 14'h3000;
            d2_p1     <= 2'b11;
            h_q       <= 11'd0;
            v_q       <= 10'd0;
        end else begin
            state     <= state_nxt;
            acq_err_q <= acq_err_nxt;
            d1_p0     <= vgaData;
            d2_p1     <= d1_p0[13:12];
            h_q       <= h_cnt;
            v_q       <= v_cnt;
        end
    end

    // Stage p2: registered pixel, error and frame outputs
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 9'd0;
            pix_rgb     <= 12'd0;
            timing_err  <= 1'b0;
            err_count   <= 8'd0;
            frame_done  <= 1'b0;
            frame_sum   <= 16'd0;
            frame_count <= 16'd0;
            run_sum     <= 16'd0;
        end else begin
            pix_valid  <= pix_load;
            timing_err <= viol;
            frame_done <= frame_end;
            if (pix_load) begin
                pix_x   <= 10'(h_cnt - H_ACT_LO);
                pix_y   <= 9'(v_cnt - V_ACT_LO);
                pix_rgb <= d1_p0[11:0];
            end
            if (viol) err_count <= sat_inc_e(err_count);
            if ((state != LOCKED) || viol) begin
                run_sum <= 16'd0;
            end else if (frame_end) begin
                frame_sum   <= sum_nxt;
                frame_count <= frame_count + 16'd1;
                run_sum     <= 16'd0;
            end else begin
                run_sum <= sum_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_monitor.sv
// Bench for vga_monitor using a reduced video mode so whole frames stay short;
// frame-level expectations come from a table, pixels from a driven-sample scoreboard.
module tb_vga_monitor;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    logic        clk;
    logic        rst;
    logic [13:0] vga_data;
    logic        locked;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [15:0] frame_count;
    logic        timing_err;
    logic [7:0]  err_count;

    vga_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .vga_clk    (clk),
        .reset      (rst),
        .vgaData    (vga_data),
        .locked     (locked),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_rgb    (pix_rgb),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .frame_count(frame_count),
        .timing_err (timing_err),
        .err_count  (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        act;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] rgb;
    } samp_t;

    typedef struct {
        int          mode;
        int          long_line;
        int          short_line;
        logic        exp_locked;
        int          exp_done;
        logic [15:0] exp_sum;
        logic [15:0] exp_fc;
        int          exp_terr;
        logic [7:0]  exp_ecnt;
        int          exp_npix;
    } frame_rec_t;

    int    total = 0;
    int    bad   = 0;
    samp_t drv = '0;
    samp_t last_cap = '0;
    samp_t first_cap = '0;
    int    n_pix = 0;
    int    n_done = 0;
    int    n_terr = 0;
    logic        locked_at_err = 1'b0;
    logic [15:0] done_sum = '0;
    logic [15:0] done_fc = '0;
    logic [9:0]  held_x = '0;
    logic [8:0]  held_y = '0;
    logic [11:0] held_rgb = '0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Pixel outputs registered at edge E+1 belong to the sample captured at edge E
    always @(posedge clk) begin
        samp_t cap_now;
        cap_now = drv;
        #1;
        if (rst) begin
            held_x   = '0;
            held_y   = '0;
            held_rgb = '0;
        end else if (pix_valid) begin
            n_pix++;
            if (n_pix == 1) first_cap = last_cap;
            chk("pix_act", n_pix, 32'(last_cap.act), 32'd1);
            chk("pix_x", n_pix, 32'(pix_x), 32'(last_cap.x));
            chk("pix_y", n_pix, 32'(pix_y), 32'(last_cap.y));
            chk("pix_rgb", n_pix, 32'(pix_rgb), 32'(last_cap.rgb));
            held_x   = pix_x;
            held_y   = pix_y;
            held_rgb = pix_rgb;
        end else begin
            chk("pix_hold", 0, 32'({pix_x, pix_y, pix_rgb}), 32'({held_x, held_y, held_rgb}));
        end
        if (frame_done) begin
            n_done++;
            done_sum = frame_sum;
            done_fc  = frame_count;
        end
        if (timing_err) begin
            n_terr++;
            locked_at_err = locked;
        end
        last_cap = cap_now;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vga_data = 14'h3FFF;
            drv      = '0;
        end
    endtask

    task automatic drive_frame(input int mode, input int long_line, input int short_line, input int nlines);
        int          len;
        int          sw;
        logic        act;
        logic [9:0]  xv;
        logic [11:0] rgb;
        for (int l = 0; l < nlines; l++) begin
            len = (l == long_line) ? HT + 1 : HT;
            sw  = (l == short_line) ? HS - 1 : HS;
            for (int c = 0; c < len; c++) begin
                act = (c >= HS + HB) && (c < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
                xv  = 10'(c - (HS + HB));
                if (!act)          rgb = 12'hABC;
                else if (mode == 1) rgb = {xv[3:0], xv[3:0], xv[3:0]};
                else               rgb = 12'h00F;
                @(negedge clk);
                vga_data = {(c >= sw), (l >= VS), rgb};
                drv.act  = act;
                drv.hc   = 11'(c);
                drv.vc   = 10'(l);
                drv.x    = xv;
                drv.y    = 9'(l - (VS + VB));
                drv.rgb  = rgb;
            end
        end
    endtask

    task automatic apply(input frame_rec_t r, input int idx);
        n_pix  = 0;
        n_done = 0;
        n_terr = 0;
        drive_frame(r.mode, r.long_line, r.short_line, VT);
        chk("locked", idx, 32'(locked), 32'(r.exp_locked));
        chk("done_pulses", idx, 32'(n_done), 32'(r.exp_done));
        if (r.exp_done > 0) begin
            chk("frame_sum", idx, 32'(done_sum), 32'(r.exp_sum));
            chk("count_at_done", idx, 32'(done_fc), 32'(r.exp_fc));
        end
        chk("frame_count", idx, 32'(frame_count), 32'(r.exp_fc));
        chk("terr_pulses", idx, 32'(n_terr), 32'(r.exp_terr));
        if (r.exp_terr > 0) chk("locked_at_err", idx, 32'(locked_at_err), 32'd0);
        chk("err_count", idx, 32'(err_count), 32'(r.exp_ecnt));
        chk("npix", idx, 32'(n_pix), 32'(r.exp_npix));
        if (r.exp_npix > 0) begin
            chk("first_hc", idx, 32'(first_cap.hc), 32'(HS + HB));
            chk("first_vc", idx, 32'(first_cap.vc), 32'(VS + VB));
        end
    endtask

    frame_rec_t tbl [13];
    frame_rec_t rec_tbl [3];

    initial begin
        // 48 pixels per frame: constant 00F sums to 720; gradient x*0x111 sums to 6*28*273 = 45864
        tbl[0]  = '{0, -1, -1, 1'b0, 0, 16'h0000, 16'd0, 0, 8'd0, 0};
        tbl[1]  = '{0, -1, -1, 1'b1, 0, 16'h0000, 16'd0, 0, 8'd0, 48};
        tbl[2]  = '{0, -1, -1, 1'b1, 1, 16'h02D0, 16'd1, 0, 8'd0, 48};
        tbl[3]  = '{1, -1, -1, 1'b1, 1, 16'h02D0, 16'd2, 0, 8'd0, 48};
        tbl[4]  = '{1,  5, -1, 1'b0, 1, 16'hB328, 16'd3, 1, 8'd1, 16};
        tbl[5]  = '{0, -1, -1, 1'b0, 0, 16'h0000, 16'd3, 0, 8'd1, 0};
        tbl[6]  = '{0, -1, -1, 1'b1, 0, 16'h0000, 16'd3, 0, 8'd1, 48};
        tbl[7]  = '{0, -1, -1, 1'b1, 1, 16'h02D0, 16'd4, 0, 8'd1, 48};
        tbl[8]  = '{0, -1,  3, 1'b0, 1, 16'h02D0, 16'd5, 1, 8'd2, 0};
        tbl[9]  = '{0, -1,  3, 1'b0, 0, 16'h0000, 16'd5, 1, 8'd3, 0};
        tbl[10] = '{0, -1, -1, 1'b0, 0, 16'h0000, 16'd5, 0, 8'd3, 0};
        tbl[11] = '{0, -1, -1, 1'b1, 0, 16'h0000, 16'd5, 0, 8'd3, 48};
        tbl[12] = '{0, -1, -1, 1'b1, 1, 16'h02D0, 16'd6, 0, 8'd3, 48};
        rec_tbl[0] = '{0, -1, -1, 1'b0, 0, 16'h0000, 16'd0, 0, 8'd0, 0};
        rec_tbl[1] = '{0, -1, -1, 1'b1, 0, 16'h0000, 16'd0, 0, 8'd0, 48};
        rec_tbl[2] = '{0, -1, -1, 1'b1, 1, 16'h02D0, 16'd1, 0, 8'd0, 48};

        rst      = 1'b1;
        vga_data = 14'h3FFF;
        repeat (10) @(negedge clk);
        chk("rst_ctrl", 0, 32'({locked, pix_valid, frame_done, timing_err}), 32'd0);
        chk("rst_cnt", 0, 32'({frame_count, err_count}), 32'd0);
        chk("rst_pix", 0, 32'({pix_x, pix_y, pix_rgb}), 32'd0);
        chk("rst_sum", 0, 32'(frame_sum), 32'd0);
        rst = 1'b0;
        idle(5);
        chk("post_rst", 0, 32'({locked, pix_valid, frame_done, timing_err, err_count}), 32'd0);
        chk("rst_terr", 0, 32'(n_terr), 32'd0);

        for (int i = 0; i < 13; i++) apply(tbl[i], i);

        // Asynchronous reset in the middle of a locked frame
        drive_frame(0, -1, -1, 6);
        chk("pre_rst_locked", 0, 32'(locked), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_locked", 0, 32'(locked), 32'd0);
        chk("mid_rst_fc", 0, 32'(frame_count), 32'd0);
        chk("mid_rst_ecnt", 0, 32'(err_count), 32'd0);
        chk("mid_rst_pix", 0, 32'({pix_valid, pix_x, pix_y}), 32'd0);
        chk("mid_rst_sum", 0, 32'(frame_sum), 32'd0);
        idle(3);
        rst = 1'b0;
        idle(4);
        for (int i = 0; i < 3; i++) apply(rec_tbl[i], 100 + i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
